stopwatch_counter: RTL and testbench
====================================

# stopwatch_counter

BCD MM:SS stopwatch core fed by the clock-generation FSM. Consumes single-cycle tick enables derived from the FSM's 1 Hz and adjust-rate clocks, plus the debounced `sel`, `adj` and `pause` controls. Produces four BCD digits and a per-digit blank mask for the downstream 7-segment multiplexer, which runs off the 500 Hz clock.

## Interface
- `MIN_LIMIT`, default 59: highest minutes value; legal range 1..99; wraps to 0 after it.
- `clk` input 1: system clock; all state changes on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `tick_1hz` input 1: one-`clk`-cycle pulse at 1 Hz; drives normal counting.
- `tick_adj` input 1: one-`clk`-cycle pulse at 2 Hz; drives adjust increments and blink phase.
- `sel` input 1: adjust target; 0 = minutes, 1 = seconds.
- `adj` input 1: level; 1 = adjust mode.
- `pause` input 1: debounced level; each rising edge toggles run/pause.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` output 4 each: BCD digits, registered.
- `blank` output 4: digit blank mask {min_tens, min_ones, sec_tens, sec_ones}; 1 = blank.
- `running` output 1: 1 when counting in normal mode.

## Operation
- Reset values: all digits 0, `blank` = 4'b0000, `running` = 1, state RUN, blink phase 0, pause edge register 0.
- `pause` rising edge is detected against a one-cycle-delayed copy of `pause`.
- States:
  - RUN: on `tick_1hz`, seconds +1.
    - sec 59 -> 00 carries into minutes +1.
    - Minutes at `MIN_LIMIT` -> 0.
    - Full wrap `MIN_LIMIT`:59 -> 00:00.
  - PAUSED: digits hold; ticks ignored.
  - ADJUST: entered whenever `adj`=1, from either RUN or PAUSED.
    - Normal counting is stopped.
    - On `tick_adj`, the selected field increments by 1 with no carry: seconds 59 -> 00 leaves minutes unchanged; minutes `MIN_LIMIT` -> 0.
    - `tick_1hz` is ignored.
- Transitions:
  - RUN <-> PAUSED on a pause edge while `adj`=0.
  - Any state -> ADJUST when `adj`=1.
  - ADJUST -> RUN or PAUSED when `adj`=0, according to the pause flag.
- The pause flag toggles on every pause edge, including while in ADJUST; it takes effect after `adj` drops.
- `running` = 1 only in RUN.
- BCD arithmetic: ones digit 9 -> 0 carries into tens. Tens and ones never leave 0..9. Minutes compare against `MIN_LIMIT` as a two-digit BCD value.

## Timing
- All outputs are registered. A digit change is visible after the rising edge that samples `tick_1hz`/`tick_adj` = 1: latency 1 cycle from the pulse.
- Simultaneous pause edge and `tick_1hz` in RUN: the tick is applied, because the decision uses the pre-edge pause flag. PAUSED is entered on the same edge, and later ticks are ignored.
- Simultaneous `adj` rise and `tick_1hz`: the tick is ignored; ADJUST takes priority on that edge.
- `sel` is sampled on the `tick_adj` edge; changing `sel` between pulses is legal.
- `rst` mid-count clears everything immediately (asynchronous); the first tick after release counts from 00:00.
- Ticks wider than one cycle are out of contract; each high cycle counts.

## Configuration
- `STOPWATCH_BLINK_EN` defined:
  - In ADJUST, the blink phase toggles on each `tick_adj`.
  - While phase = 1, `blank` = 4'b1100 for sel=0 or 4'b0011 for sel=1.
  - Otherwise `blank` = 0.
  - The phase resets to 0 on entering ADJUST.
- Not defined: `blank` is constant 4'b0000 and the phase register is absent.

## Test plan
- Reset release, 61 `tick_1hz` pulses -> digits 01:01, `running`=1.
- Preload to 59:58 via adjust, return to run, 2 ticks -> 00:00 (`MIN_LIMIT`=59); with `MIN_LIMIT`=5, 05:59 + 1 tick -> 00:00.
- At 00:10 pulse `pause`, 5 ticks -> holds 00:10 and `running`=0; pulse `pause`, 3 ticks -> 00:13.
- `adj`=1, `sel`=1, from 00:58: 3 `tick_adj` -> 00:01 with minutes unchanged; `sel`=0, 2 `tick_adj` -> 02:01; `tick_1hz` pulses during adjust have no effect.
- Pause edge and `tick_1hz` on the same cycle at 00:20 -> 00:21, then PAUSED; assert `rst` mid-count -> 00:00 immediately.
- With `STOPWATCH_BLINK_EN`, `adj`=1, `sel`=0: `blank` alternates 4'b1100 / 4'b0000 on successive `tick_adj`; without the macro it stays 4'b0000.

Source files
------------

// File: rtl/stopwatch_counter.sv
// BCD MM:SS stopwatch core with run/pause/adjust modes and a digit blank mask.
// Optional adjust-mode digit blinking is enabled by defining STOPWATCH_BLINK_EN.
module stopwatch_counter #(
    parameter int MIN_LIMIT = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_adj,
    input  logic       sel,
    input  logic       adj,
    input  logic       pause,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] blank,
    output logic       running
);

    typedef enum logic [1:0] {RUN, PAUSED, ADJUST} state_t;

    localparam logic [3:0] MIN_T = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] MIN_O = 4'(MIN_LIMIT % 10);

    state_t     state;
    state_t     state_next;
    logic       pause_d;
    logic       pause_flag;
    logic       pause_flag_next;
    logic       pause_edge;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;

    // Two-digit BCD increment that wraps to 00 once the value reaches the limit.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input logic [3:0] lim_t,
                                           input logic [3:0] lim_o);
        if (v[7:4] == lim_t && v[3:0] == lim_o)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign pause_edge      = pause & ~pause_d;
    assign pause_flag_next = pause_flag ^ pause_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            pause_d    <= 1'b0;
            pause_flag <= 1'b0;
        end else begin
            state      <= state_next;
            pause_d    <= pause;
            pause_flag <= pause_flag_next;
        end
    end

    // The pause flag keeps toggling in ADJUST so leaving adjust lands in the right mode.
    always_comb begin
        state_next = state;
        if (adj)
            state_next = ADJUST;
        else if (pause_flag_next)
            state_next = PAUSED;
        else
            state_next = RUN;
    end

    always_comb begin
        running = 1'b0;
        if (state == RUN)
            running = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_bcd <= 8'h00;
            min_bcd <= 8'h00;
        end else if (state == RUN && !adj && tick_1hz) begin
            sec_bcd <= bcd_inc(sec_bcd, 4'd5, 4'd9);
            if (sec_bcd == 8'h59)
                min_bcd <= bcd_inc(min_bcd, MIN_T, MIN_O);
        end else if (state == ADJUST && tick_adj) begin
            if (sel)
                sec_bcd <= bcd_inc(sec_bcd, 4'd5, 4'd9);
            else
                min_bcd <= bcd_inc(min_bcd, MIN_T, MIN_O);
        end
    end

    assign min_tens = min_bcd[7:4];
    assign min_ones = min_bcd[3:0];
    assign sec_tens = sec_bcd[7:4];
    assign sec_ones = sec_bcd[3:0];

`ifdef STOPWATCH_BLINK_EN
    logic phase;
    logic phase_next;
    logic [3:0] blank_next;

    // Phase restarts at 0 on adjust entry so the first blink follows the first adjust tick.
    always_comb begin
        phase_next = phase;
        if (state != ADJUST && state_next == ADJUST)
            phase_next = 1'b0;
        else if (state == ADJUST && tick_adj)
            phase_next = ~phase;
    end

    always_comb begin
        blank_next = 4'b0000;
        if (state_next == ADJUST && phase_next)
            blank_next = sel ? 4'b0011 : 4'b1100;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 1'b0;
            blank <= 4'b0000;
        end else begin
            phase <= phase_next;
            blank <= blank_next;
        end
    end
`else
    assign blank = 4'b0000;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed self-checking bench for stopwatch_counter (MIN_LIMIT 59 and 5 instances).
module tb_stopwatch_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       tick_adj = 1'b0;
    logic       sel = 1'b0;
    logic       adj = 1'b0;
    logic       pause = 1'b0;

    logic [3:0] min_tens, min_ones, sec_tens, sec_ones, blank;
    logic       running;
    logic [3:0] d5_min_tens, d5_min_ones, d5_sec_tens, d5_sec_ones, d5_blank;
    logic       d5_running;

    logic [15:0] digits;
    logic [15:0] d5_digits;

    int errors = 0;
    int checks = 0;

`ifdef STOPWATCH_BLINK_EN
    localparam logic [3:0] BLANK_MIN = 4'b1100;
`else
    localparam logic [3:0] BLANK_MIN = 4'b0000;
`endif

    assign digits    = {min_tens, min_ones, sec_tens, sec_ones};
    assign d5_digits = {d5_min_tens, d5_min_ones, d5_sec_tens, d5_sec_ones};

    always #5 clk = ~clk;

    stopwatch_counter #(.MIN_LIMIT(59)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_adj(tick_adj),
        .sel(sel), .adj(adj), .pause(pause),
        .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones),
        .blank(blank), .running(running)
    );

    stopwatch_counter #(.MIN_LIMIT(5)) dut5 (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_adj(tick_adj),
        .sel(sel), .adj(adj), .pause(pause),
        .min_tens(d5_min_tens), .min_ones(d5_min_ones),
        .sec_tens(d5_sec_tens), .sec_ones(d5_sec_ones),
        .blank(d5_blank), .running(d5_running)
    );

    task automatic check_output(input string tag, input logic [15:0] observed,
                                input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic pulse_1hz(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick_1hz = 1'b1;
            @(negedge clk) tick_1hz = 1'b0;
        end
    endtask

    task automatic pulse_adj(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick_adj = 1'b1;
            @(negedge clk) tick_adj = 1'b0;
        end
    endtask

    task automatic pulse_pause();
        @(negedge clk) pause = 1'b1;
        @(negedge clk) pause = 1'b0;
    endtask

    task automatic set_adj(input logic v);
        @(negedge clk) adj = v;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        $display("[TB] stopwatch_counter bench start");
        repeat (3) @(negedge clk);
        check_output("reset_digits", digits, 16'h0000);
        check_output("reset_running", {15'd0, running}, 16'd1);
        check_output("reset_blank", {12'd0, blank}, 16'd0);
        rst = 1'b0;

        // 61 seconds of normal counting
        pulse_1hz(61);
        check_output("count61_digits", digits, 16'h0101);
        check_output("count61_running", {15'd0, running}, 16'd1);
        check_output("count61_d5_digits", d5_digits, 16'h0101);

        // Preload 05:59 on both instances, checking blink on the first adjust ticks
        do_reset();
        set_adj(1'b1);
        check_output("adj_entry_blank", {12'd0, blank}, 16'd0);
        sel = 1'b0;
        pulse_adj(1);
        check_output("blink_phase1", {12'd0, blank}, {12'd0, BLANK_MIN});
        pulse_adj(1);
        check_output("blink_phase0", {12'd0, blank}, 16'd0);
        pulse_adj(3);
        sel = 1'b1;
        pulse_adj(59);
        check_output("preload_0559", digits, 16'h0559);
        check_output("preload_d5_0559", d5_digits, 16'h0559);
        set_adj(1'b0);
        pulse_1hz(1);
        check_output("lim59_0600", digits, 16'h0600);
        check_output("lim5_wrap", d5_digits, 16'h0000);

        // Preload 59:58 and wrap to 00:00
        set_adj(1'b1);
        sel = 1'b0;
        pulse_adj(53);
        sel = 1'b1;
        pulse_adj(58);
        check_output("preload_5958", digits, 16'h5958);
        set_adj(1'b0);
        check_output("adj_exit_running", {15'd0, running}, 16'd1);
        pulse_1hz(1);
        check_output("at_5959", digits, 16'h5959);
        pulse_1hz(1);
        check_output("full_wrap", digits, 16'h0000);

        // Pause and resume
        pulse_1hz(10);
        check_output("at_0010", digits, 16'h0010);
        pulse_pause();
        pulse_1hz(5);
        check_output("paused_hold", digits, 16'h0010);
        check_output("paused_running", {15'd0, running}, 16'd0);
        pulse_pause();
        pulse_1hz(3);
        check_output("resumed_0013", digits, 16'h0013);
        check_output("resumed_running", {15'd0, running}, 16'd1);

        // Adjust seconds without carry, then minutes; 1 Hz ticks ignored
        pulse_1hz(45);
        check_output("at_0058", digits, 16'h0058);
        set_adj(1'b1);
        sel = 1'b1;
        pulse_adj(3);
        check_output("adj_sec_nocarry", digits, 16'h0001);
        check_output("adj_running", {15'd0, running}, 16'd0);
        pulse_1hz(4);
        check_output("adj_ignores_1hz", digits, 16'h0001);
        sel = 1'b0;
        pulse_adj(2);
        check_output("adj_min_0201", digits, 16'h0201);
        set_adj(1'b0);
        check_output("adj_back_run", {15'd0, running}, 16'd1);

        // adj rising together with a 1 Hz tick: tick is dropped
        @(negedge clk);
        adj = 1'b1;
        tick_1hz = 1'b1;
        @(negedge clk) tick_1hz = 1'b0;
        check_output("adj_tick_collide", digits, 16'h0201);
        check_output("adj_tick_running", {15'd0, running}, 16'd0);
        set_adj(1'b0);

        // Pause edge during adjust takes effect once adj drops
        set_adj(1'b1);
        pulse_pause();
        set_adj(1'b0);
        check_output("pause_in_adj_running", {15'd0, running}, 16'd0);
        pulse_1hz(2);
        check_output("pause_in_adj_hold", digits, 16'h0201);
        pulse_pause();
        check_output("pause_in_adj_resume", {15'd0, running}, 16'd1);

        // Pause edge coincident with a tick at 00:20
        do_reset();
        pulse_1hz(20);
        check_output("at_0020", digits, 16'h0020);
        @(negedge clk);
        pause = 1'b1;
        tick_1hz = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        tick_1hz = 1'b0;
        check_output("pause_tick_collide", digits, 16'h0021);
        check_output("pause_tick_running", {15'd0, running}, 16'd0);
        pulse_1hz(3);
        check_output("pause_tick_hold", digits, 16'h0021);

        // Asynchronous reset mid-count
        pulse_pause();
        pulse_1hz(5);
        check_output("at_0026", digits, 16'h0026);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_output("async_rst_digits", digits, 16'h0000);
        check_output("async_rst_running", {15'd0, running}, 16'd1);
        @(negedge clk) rst = 1'b0;
        pulse_1hz(1);
        check_output("after_rst_0001", digits, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
